// File: rtl/alu_pkg.sv
// Shared ALU control codes and multiplier sequencer state encoding.
// Imported by the sequencer and by the parent datapath that owns the ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_DBL,
        S_SHR,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Iterative shift-add MUL (low XLEN bits) that borrows the shared ALU while busy.
// Optional ALU_SEQ_EARLY_EXIT_EN: finish as soon as the multiplier is exhausted.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            alu_own,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            req_ready_q, rsp_valid_q, own_q, own_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]      ctrl_q, ctrl_d;

`ifndef ALU_SEQ_EARLY_EXIT_EN
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;
`endif

    always_comb begin
        state_d  = state_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    prod_d   = '0;
                    mcand_d  = req_a;
                    mplier_d = req_b;
                    cnt_d    = '0;
                    state_d  = req_b[0] ? S_ADD : S_DBL;
`ifdef ALU_SEQ_EARLY_EXIT_EN
                    if (req_b == '0) state_d = S_DONE;
`endif
                end
            end
            S_ADD: begin
                prod_d  = alu_result;
                state_d = S_DBL;
            end
            S_DBL: begin
                mcand_d = alu_result;
                state_d = S_SHR;
            end
            S_SHR: begin
                mplier_d = alu_result;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = S_DONE;
`ifdef ALU_SEQ_EARLY_EXIT_EN
                else if (alu_zero) state_d = S_DONE;
`endif
                else if (alu_result[0]) state_d = S_ADD;
                else state_d = S_DBL;
            end
            S_DONE: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ALU drive is precomputed from the next state so the outputs come straight from flops.
    always_comb begin
        own_d   = 1'b0;
        alu_a_d = '0;
        alu_b_d = '0;
        ctrl_d  = ALU_ADD;
        unique case (state_d)
            S_ADD: begin
                own_d   = 1'b1;
                alu_a_d = prod_d;
                alu_b_d = mcand_d;
            end
            S_DBL: begin
                own_d   = 1'b1;
                alu_a_d = mcand_d;
                alu_b_d = mcand_d;
            end
            S_SHR: begin
                own_d   = 1'b1;
                alu_a_d = mplier_d;
                alu_b_d = XLEN'(1);
                ctrl_d  = ALU_SRL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            prod_q      <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            own_q       <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            ctrl_q      <= ALU_ADD;
        end else begin
            state_q     <= state_d;
            prod_q      <= prod_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            req_ready_q <= (state_d == S_IDLE);
            rsp_valid_q <= (state_d == S_DONE);
            own_q       <= own_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = prod_q;
    assign alu_own    = own_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = ctrl_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a behavioural ALU beside it.
// Expected latencies follow ALU_SEQ_EARLY_EXIT_EN when it is defined.
module tb_alu_mul_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic        alu_own;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;

    always #5 clk = ~clk;

    alu_mul_sequencer #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .alu_own   (alu_own),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_result(alu_result),
        .alu_zero  (alu_zero)
    );

    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_XOR: alu_result = alu_a ^ alu_b;
            ALU_SRL: alu_result = alu_a >> alu_b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          ops;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc = 0;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endfunction

    always @(posedge clk) cyc++;

    int   acc_cyc = 0;
    int   ops = 0;
    int   lat = 0;
    bit   seen = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (!rst_n) begin
            ops  = 0;
            seen = 1'b0;
        end else begin
            if (alu_own) begin
                ops++;
                chk("own_ctrl_legal", 32'(alu_ctrl == ALU_ADD || alu_ctrl == ALU_SRL), 32'd1);
                if (alu_ctrl == ALU_SRL) chk("srl_operand_b", alu_b, 32'd1);
            end else begin
                chk("free_alu_a", alu_a, 32'd0);
                chk("free_alu_b", alu_b, 32'd0);
                chk("free_alu_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
            end
            if (rsp_valid && !seen) begin
                seen = 1'b1;
                lat  = cyc + 1 - acc_cyc;
            end
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_bad++;
                    $display("FAIL spurious_rsp: got %0h expected none", rsp_result);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_latency", 32'(lat), 32'(e.lat));
                    chk("alu_op_count", 32'(ops), 32'(e.ops));
                end
                seen = 1'b0;
            end
            if (req_valid && req_ready) begin
                acc_cyc = cyc + 1;
                ops     = 0;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int l, input int o);
        int t = 0;
        while (!req_ready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        sbq.push_back('{res, l, o});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_pending", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_alu_own", 32'(alu_own), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

`ifdef ALU_SEQ_EARLY_EXIT_EN
        issue(32'd3, 32'd5, 32'd15, 9, 8);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 97, 96);
        issue(32'h1234, 32'd0, 32'd0, 1, 0);
        issue(32'h80000000, 32'd2, 32'd0, 6, 5);
        issue(32'hFFFFFFFD, 32'd4, 32'hFFFFFFF4, 8, 7);
`else
        issue(32'd3, 32'd5, 32'd15, 67, 66);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 97, 96);
        issue(32'h1234, 32'd0, 32'd0, 65, 64);
        issue(32'h80000000, 32'd2, 32'd0, 66, 65);
        issue(32'hFFFFFFFD, 32'd4, 32'hFFFFFFF4, 66, 65);
`endif
        drain();

        rsp_ready = 1'b0;
`ifdef ALU_SEQ_EARLY_EXIT_EN
        issue(32'd6, 32'd7, 32'd42, 10, 9);
`else
        issue(32'd6, 32'd7, 32'd42, 68, 67);
`endif
        for (int t = 0; t < 300 && !rsp_valid; t++) begin
            @(posedge clk); #1;
        end
        chk("bp_rsp_valid_seen", 32'(rsp_valid), 32'd1);
        req_valid = 1'b1;
        req_a     = 32'd9;
        req_b     = 32'd9;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_result", rsp_result, 32'd42);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        drain();

        req_valid = 1'b1;
        req_a     = 32'd7;
        req_b     = 32'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midop_busy", 32'(alu_own), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midop_rst_own", 32'(alu_own), 32'd0);
        chk("midop_rst_ready", 32'(req_ready), 32'd1);
        chk("midop_rst_valid", 32'(rsp_valid), 32'd0);
        chk("midop_rst_result", rsp_result, 32'd0);
        chk("midop_rst_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
`ifdef ALU_SEQ_EARLY_EXIT_EN
        issue(32'd2, 32'd6, 32'd12, 9, 8);
`else
        issue(32'd2, 32'd6, 32'd12, 67, 66);
`endif
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("final_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("final_req_ready", 32'(req_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
